mc51_xbus_arbiter: RTL and testbench

//  Shares the single external memory port between the mcs_51 core bus (psen_n/rd_n/we_n) and a

---
 rtl/mc51_xbus_arbiter_if.sv | 47 ++++
 rtl/mc51_xbus_arbiter.sv | 114 +++++++++++
 tb/tb_mc51_xbus_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mc51_xbus_arbiter_if.sv
// Bus bundle between the mcs_51 core, the secondary (DMA/debug) requester and the
// external memory port. The arbiter uses the master view; the environment uses slave.
interface mc51_xbus_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_psen_n;
  logic              cpu_rd_n;
  logic              cpu_we_n;
  logic              cpu_ready;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic              dma_done;
  logic [DATA_W-1:0] dma_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ce_n;
  logic              mem_oe_n;
  logic              mem_we_n;

  modport master (
    input  cpu_addr, cpu_wdata, cpu_psen_n, cpu_rd_n, cpu_we_n,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_ready,
    output dma_gnt, dma_done, dma_rdata,
    output mem_addr, mem_wdata, mem_ce_n, mem_oe_n, mem_we_n
  );

  modport slave (
    output cpu_addr, cpu_wdata, cpu_psen_n, cpu_rd_n, cpu_we_n,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_ready,
    input  dma_gnt, dma_done, dma_rdata,
    input  mem_addr, mem_wdata, mem_ce_n, mem_oe_n, mem_we_n
  );
endinterface

// File: rtl/mc51_xbus_arbiter.sv
// Shares one external memory port between the mcs_51 core bus and a secondary requester,
// holding memory strobes WAIT_CYC cycles per access and stalling the core via cpu_ready.
module mc51_xbus_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int WAIT_CYC   = 2,
  parameter int STARVE_LIM = 4
) (
  input  logic                  clk,
  input  logic                  sys_rst_n,
  mc51_xbus_arbiter_if.master   bus
);
  localparam int CNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  localparam int STV_W = $clog2(STARVE_LIM + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYC - 1);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIM);

  typedef enum logic [2:0] {IDLE, CPU_ACC, CPU_RSP, DMA_ACC, DMA_RSP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STV_W-1:0]  starve_q, starve_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;

  logic cpu_req, cpu_wr, acc, dma_forced;

  assign cpu_req    = ~bus.cpu_psen_n | ~bus.cpu_rd_n | ~bus.cpu_we_n;
  assign cpu_wr     = ~bus.cpu_we_n;
  assign acc        = (state_q == CPU_ACC) || (state_q == DMA_ACC);
  assign dma_forced = bus.dma_req && (starve_q == STV_MAX);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    starve_d    = starve_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (cpu_req && !dma_forced) begin
          state_d = CPU_ACC;
          addr_d  = bus.cpu_addr;
          wdata_d = bus.cpu_wdata;
          we_d    = cpu_wr;
          // Counter cannot be at the limit here, since that case hands the port to DMA.
          if (bus.dma_req) starve_d = starve_q + STV_W'(1);
        end else if (bus.dma_req) begin
          state_d  = DMA_ACC;
          addr_d   = bus.dma_addr;
          wdata_d  = bus.dma_wdata;
          we_d     = bus.dma_we;
          starve_d = '0;
        end
        if (!bus.dma_req) starve_d = '0;
      end
      CPU_ACC, DMA_ACC: begin
        if (cnt_q == CNT_LAST) begin
          state_d = (state_q == CPU_ACC) ? CPU_RSP : DMA_RSP;
          if (!we_q) begin
            if (state_q == CPU_ACC) cpu_rdata_d = bus.mem_rdata;
            else                    dma_rdata_d = bus.mem_rdata;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CPU_RSP, DMA_RSP: state_d = IDLE;
      default:          state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      starve_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  // Strobes decode straight from state so an async reset releases them immediately.
  assign bus.mem_ce_n  = ~acc;
  assign bus.mem_oe_n  = ~(acc && !we_q);
  assign bus.mem_we_n  = ~(acc && we_q);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  assign bus.cpu_ready = ~(cpu_req && (state_q != CPU_RSP));
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dma_gnt   = (state_q == DMA_ACC) || (state_q == DMA_RSP);
  assign bus.dma_done  = (state_q == DMA_RSP);
  assign bus.dma_rdata = dma_rdata_q;
endmodule

// File: tb/tb_mc51_xbus_arbiter.sv
// Directed bench for mc51_xbus_arbiter: per-cycle vector table plus hand-written
// starvation and mid-access reset sequences, against a simple SRAM model.
module tb_mc51_xbus_arbiter;
  logic clk = 1'b0;
  logic sys_rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mc51_xbus_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus ();

  mc51_xbus_arbiter #(
    .ADDR_W(16), .DATA_W(8), .WAIT_CYC(2), .STARVE_LIM(4)
  ) dut (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  logic [7:0] mem [0:65535];
  assign bus.mem_rdata = (!bus.mem_ce_n && !bus.mem_oe_n) ? mem[bus.mem_addr] : 8'h00;
  always @(posedge clk) if (!bus.mem_ce_n && !bus.mem_we_n) mem[bus.mem_addr] <= bus.mem_wdata;

  typedef struct {
    logic [2:0]  cs;     // {psen_n, rd_n, we_n}
    logic [15:0] caddr;
    logic [7:0]  cwd;
    logic        dreq;
    logic        dwe;
    logic [15:0] daddr;
    logic [7:0]  dwd;
    logic [2:0]  eflg;   // {cpu_ready, dma_gnt, dma_done}
    logic [2:0]  estb;   // {mem_ce_n, mem_oe_n, mem_we_n}
    logic [15:0] eaddr;
    logic [7:0]  ewd;
    logic [7:0]  ecrd;
    logic [7:0]  edrd;
  } vec_t;

  vec_t vecs[$];

  localparam logic [2:0] CS_NONE = 3'b111, CS_PSEN = 3'b011, CS_RD = 3'b101, CS_RDWE = 3'b100;
  localparam logic [2:0] S_OFF = 3'b111, S_RD = 3'b001, S_WR = 3'b010;
  localparam logic [2:0] F_IDLE = 3'b100, F_WAIT = 3'b000, F_DGNT = 3'b110, F_DDONE = 3'b111;

  function automatic void add(input logic [2:0] cs, input logic [15:0] caddr, input logic [7:0] cwd,
                              input logic dreq, input logic dwe, input logic [15:0] daddr,
                              input logic [7:0] dwd, input logic [2:0] eflg, input logic [2:0] estb,
                              input logic [15:0] eaddr, input logic [7:0] ewd,
                              input logic [7:0] ecrd, input logic [7:0] edrd);
    vec_t v;
    v.cs = cs; v.caddr = caddr; v.cwd = cwd; v.dreq = dreq; v.dwe = dwe; v.daddr = daddr;
    v.dwd = dwd; v.eflg = eflg; v.estb = estb; v.eaddr = eaddr; v.ewd = ewd;
    v.ecrd = ecrd; v.edrd = edrd;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] cs, input logic [15:0] caddr, input logic [7:0] cwd,
                       input logic dreq, input logic dwe, input logic [15:0] daddr,
                       input logic [7:0] dwd);
    {bus.cpu_psen_n, bus.cpu_rd_n, bus.cpu_we_n} = cs;
    bus.cpu_addr = caddr; bus.cpu_wdata = cwd;
    bus.dma_req = dreq; bus.dma_we = dwe; bus.dma_addr = daddr; bus.dma_wdata = dwd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    mem[16'h0000] = 8'h75;
    drive(CS_NONE, 16'h0, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0);

    //   cs       caddr    cwd   dreq dwe daddr    dwd    flags    strobes eaddr    ewd    crd    drd
    add(CS_NONE, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, F_IDLE,  S_OFF, 16'h0000, 8'h00, 8'h00, 8'h00);
    // CPU code fetch from 0x0000
    add(CS_PSEN, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, F_WAIT,  S_OFF, 16'h0000, 8'h00, 8'h00, 8'h00);
    add(CS_PSEN, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, F_WAIT,  S_RD,  16'h0000, 8'h00, 8'h00, 8'h00);
    add(CS_PSEN, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, F_WAIT,  S_RD,  16'h0000, 8'h00, 8'h00, 8'h00);
    add(CS_PSEN, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, F_IDLE,  S_OFF, 16'h0000, 8'h00, 8'h75, 8'h00);
    add(CS_NONE, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, F_IDLE,  S_OFF, 16'h0000, 8'h00, 8'h75, 8'h00);
    // DMA write 0x1234 <- 0xA5, then read back
    add(CS_NONE, 16'h0000, 8'h00, 1, 1, 16'h1234, 8'hA5, F_IDLE,  S_OFF, 16'h0000, 8'h00, 8'h75, 8'h00);
    add(CS_NONE, 16'h0000, 8'h00, 1, 1, 16'h1234, 8'hA5, F_DGNT,  S_WR,  16'h1234, 8'hA5, 8'h75, 8'h00);
    add(CS_NONE, 16'h0000, 8'h00, 1, 1, 16'h1234, 8'hA5, F_DGNT,  S_WR,  16'h1234, 8'hA5, 8'h75, 8'h00);
    add(CS_NONE, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, F_DDONE, S_OFF, 16'h0000, 8'h00, 8'h75, 8'h00);
    add(CS_NONE, 16'h0000, 8'h00, 1, 0, 16'h1234, 8'h00, F_IDLE,  S_OFF, 16'h0000, 8'h00, 8'h75, 8'h00);
    add(CS_NONE, 16'h0000, 8'h00, 1, 0, 16'h1234, 8'h00, F_DGNT,  S_RD,  16'h1234, 8'h00, 8'h75, 8'h00);
    add(CS_NONE, 16'h0000, 8'h00, 1, 0, 16'h1234, 8'h00, F_DGNT,  S_RD,  16'h1234, 8'h00, 8'h75, 8'h00);
    add(CS_NONE, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, F_DDONE, S_OFF, 16'h0000, 8'h00, 8'h75, 8'hA5);
    add(CS_NONE, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, F_IDLE,  S_OFF, 16'h0000, 8'h00, 8'h75, 8'hA5);
    // simultaneous CPU and DMA requests, starve count 0: CPU first
    add(CS_PSEN, 16'h0000, 8'h00, 1, 0, 16'h1234, 8'h00, F_WAIT,  S_OFF, 16'h0000, 8'h00, 8'h75, 8'hA5);
    add(CS_PSEN, 16'h0000, 8'h00, 1, 0, 16'h1234, 8'h00, F_WAIT,  S_RD,  16'h0000, 8'h00, 8'h75, 8'hA5);
    add(CS_PSEN, 16'h0000, 8'h00, 1, 0, 16'h1234, 8'h00, F_WAIT,  S_RD,  16'h0000, 8'h00, 8'h75, 8'hA5);
    add(CS_PSEN, 16'h0000, 8'h00, 1, 0, 16'h1234, 8'h00, F_IDLE,  S_OFF, 16'h0000, 8'h00, 8'h75, 8'hA5);
    add(CS_NONE, 16'h0000, 8'h00, 1, 0, 16'h1234, 8'h00, F_IDLE,  S_OFF, 16'h0000, 8'h00, 8'h75, 8'hA5);
    add(CS_NONE, 16'h0000, 8'h00, 1, 0, 16'h1234, 8'h00, F_DGNT,  S_RD,  16'h1234, 8'h00, 8'h75, 8'hA5);
    add(CS_NONE, 16'h0000, 8'h00, 1, 0, 16'h1234, 8'h00, F_DGNT,  S_RD,  16'h1234, 8'h00, 8'h75, 8'hA5);
    add(CS_NONE, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, F_DDONE, S_OFF, 16'h0000, 8'h00, 8'h75, 8'hA5);
    // rd_n and we_n both low: write wins, cpu_rdata untouched
    add(CS_RDWE, 16'h0040, 8'h3C, 0, 0, 16'h0000, 8'h00, F_WAIT,  S_OFF, 16'h0000, 8'h00, 8'h75, 8'hA5);
    add(CS_RDWE, 16'h0040, 8'h3C, 0, 0, 16'h0000, 8'h00, F_WAIT,  S_WR,  16'h0040, 8'h3C, 8'h75, 8'hA5);
    add(CS_RDWE, 16'h0040, 8'h3C, 0, 0, 16'h0000, 8'h00, F_WAIT,  S_WR,  16'h0040, 8'h3C, 8'h75, 8'hA5);
    add(CS_RDWE, 16'h0040, 8'h3C, 0, 0, 16'h0000, 8'h00, F_IDLE,  S_OFF, 16'h0000, 8'h00, 8'h75, 8'hA5);
    add(CS_NONE, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, F_IDLE,  S_OFF, 16'h0000, 8'h00, 8'h75, 8'hA5);
    // xdata read of 0x0040 returns the written byte
    add(CS_RD,   16'h0040, 8'h00, 0, 0, 16'h0000, 8'h00, F_WAIT,  S_OFF, 16'h0000, 8'h00, 8'h75, 8'hA5);
    add(CS_RD,   16'h0040, 8'h00, 0, 0, 16'h0000, 8'h00, F_WAIT,  S_RD,  16'h0040, 8'h00, 8'h75, 8'hA5);
    add(CS_RD,   16'h0040, 8'h00, 0, 0, 16'h0000, 8'h00, F_WAIT,  S_RD,  16'h0040, 8'h00, 8'h75, 8'hA5);
    add(CS_RD,   16'h0040, 8'h00, 0, 0, 16'h0000, 8'h00, F_IDLE,  S_OFF, 16'h0000, 8'h00, 8'h3C, 8'hA5);
    add(CS_NONE, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, F_IDLE,  S_OFF, 16'h0000, 8'h00, 8'h3C, 8'hA5);

    repeat (3) @(posedge clk);
    #1 sys_rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      drive(vecs[i].cs, vecs[i].caddr, vecs[i].cwd, vecs[i].dreq, vecs[i].dwe,
            vecs[i].daddr, vecs[i].dwd);
      @(negedge clk);
      chk($sformatf("v%0d flags", i), 32'({bus.cpu_ready, bus.dma_gnt, bus.dma_done}), 32'(vecs[i].eflg));
      chk($sformatf("v%0d strobes", i), 32'({bus.mem_ce_n, bus.mem_oe_n, bus.mem_we_n}), 32'(vecs[i].estb));
      if (vecs[i].estb != S_OFF) chk($sformatf("v%0d mem_addr", i), 32'(bus.mem_addr), 32'(vecs[i].eaddr));
      if (vecs[i].estb == S_WR)  chk($sformatf("v%0d mem_wdata", i), 32'(bus.mem_wdata), 32'(vecs[i].ewd));
      chk($sformatf("v%0d cpu_rdata", i), 32'(bus.cpu_rdata), 32'(vecs[i].ecrd));
      chk($sformatf("v%0d dma_rdata", i), 32'(bus.dma_rdata), 32'(vecs[i].edrd));
    end

    // Starvation: back-to-back fetches with dma_req held; DMA forced after 4 CPU grants.
    begin
      int cpu_done_cnt = 0;
      bit dma_seen = 0;
      for (int k = 0; k <= 20; k++) begin
        @(posedge clk); #1;
        drive((k < 20) ? CS_PSEN : CS_NONE, 16'h0000, 8'h00, (k < 19), 1'b0, 16'h1234, 8'h00);
        @(negedge clk);
        chk($sformatf("starve k%0d ready", k), 32'(bus.cpu_ready),
            32'(((k % 4 == 3) && k < 16) || k == 20));
        chk($sformatf("starve k%0d gnt", k), 32'(bus.dma_gnt), 32'(k >= 17 && k <= 19));
        chk($sformatf("starve k%0d done", k), 32'(bus.dma_done), 32'(k == 19));
        if (bus.dma_gnt) dma_seen = 1;
        if (!dma_seen && bus.cpu_ready && !bus.cpu_psen_n) cpu_done_cnt++;
      end
      chk("starve cpu grants before dma", 32'(cpu_done_cnt), 32'd4);
      chk("starve dma_rdata", 32'(bus.dma_rdata), 32'h0000_00A5);
    end

    // Reset asserted during DMA_ACC: strobes release at once, no done after release.
    @(posedge clk); #1;
    drive(CS_NONE, 16'h0000, 8'h00, 1'b1, 1'b1, 16'h2222, 8'h5A);
    @(negedge clk);
    chk("rst idle gnt", 32'(bus.dma_gnt), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst acc strobes", 32'({bus.mem_ce_n, bus.mem_oe_n, bus.mem_we_n}), 32'(S_WR));
    #2 sys_rst_n = 1'b0;
    #1;
    chk("rst async strobes", 32'({bus.mem_ce_n, bus.mem_oe_n, bus.mem_we_n}), 32'(S_OFF));
    chk("rst async flags", 32'({bus.cpu_ready, bus.dma_gnt, bus.dma_done}), 32'(F_IDLE));
    chk("rst mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst mem_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("rst cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
    chk("rst dma_rdata", 32'(bus.dma_rdata), 32'd0);
    @(posedge clk); #1;
    drive(CS_NONE, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00);
    @(posedge clk); #1 sys_rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("post-rst k%0d flags", k), 32'({bus.cpu_ready, bus.dma_gnt, bus.dma_done}), 32'(F_IDLE));
      chk($sformatf("post-rst k%0d strobes", k), 32'({bus.mem_ce_n, bus.mem_oe_n, bus.mem_we_n}), 32'(S_OFF));
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
